// File: rtl/countdown_pkg.sv
//----------------------------------------------------------------------------
// countdown_pkg
// Shared types and the 7-segment glyph table for multi_digit_countdown.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    // Entry d is the glyph for digit d, bit order {dp,g,f,e,d,c,b,a}.
    localparam logic [9:0][7:0] SEG_GLYPHS = {
        8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
        8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage

`default_nettype wire

// File: rtl/multi_digit_countdown_tick_gen.sv
//----------------------------------------------------------------------------
// tick_gen
// Free-running divider: one-cycle tick every DIV enabled cycles; clr restarts.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_last_cnt = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick is combinational so the consumer acts on the very edge the count wraps.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == c_last_cnt) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multi_digit_countdown.sv
//----------------------------------------------------------------------------
// multi_digit_countdown
// BCD countdown timer with pause/abort and a multiplexed 7-segment display.
// Option: define COUNTDOWN_AUTO_RELOAD_EN to reload and keep running on expiry.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module multi_digit_countdown
    import countdown_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int DIGITS  = 2,
    parameter int SCAN_HZ = 1000
) (
    input  logic                  Clk100M,
    input  logic                  Rst_n,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  abort,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic                  busy,
    output logic                  paused,
    output logic                  done,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e                state_q, state_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic                  done_q, done_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [4*DIGITS-1:0]   reload_q, reload_d;
`endif

    logic                  w_tick;
    logic                  w_scan_tick;
    logic                  w_start_acc;
    logic [4*DIGITS-1:0]   w_load_clamped;
    logic [4*DIGITS-1:0]   w_count_dec;
    logic                  w_borrow;
    bcd_t                  w_dig;
    bcd_t                  w_sel_digit;

    assign w_start_acc = start && !abort && (state_q == ST_IDLE);

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (Clk100M),
        .rst_n (Rst_n),
        .en    (state_q == ST_RUN),
        .clr   (w_start_acc),
        .tick  (w_tick)
    );

    tick_gen #(.DIV(SCAN_DIV)) u_scan (
        .clk   (Clk100M),
        .rst_n (Rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .tick  (w_scan_tick)
    );

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
        assign w_load_clamped[4*gi +: 4] =
            (load_val[4*gi +: 4] > 4'd9) ? 4'd9 : load_val[4*gi +: 4];
    end

    // Ripple BCD decrement: a zero digit becomes 9 and passes the borrow upward.
    always_comb begin
        w_count_dec = count_q;
        w_borrow    = 1'b1;
        w_dig       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = count_q[4*i +: 4];
            if (w_borrow) begin
                if (w_dig == 4'd0) begin
                    w_count_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*i +: 4] = w_dig - 4'd1;
                    w_borrow              = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
        end else if (w_start_acc) begin
            count_d = w_load_clamped;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_d = w_load_clamped;
`endif
            if (w_load_clamped == '0) begin
                done_d = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (pause && (state_q != ST_IDLE)) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end else if (w_tick && (state_q == ST_RUN)) begin
            if (w_count_dec == '0) begin
                done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                count_d = reload_q;
`else
                count_d = '0;
                state_d = ST_IDLE;
`endif
            end else begin
                count_d = w_count_dec;
            end
        end
    end

    always_comb begin
        scan_idx_d = scan_idx_q;
        if (w_scan_tick) begin
            scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
    end

    always_ff @(posedge Clk100M) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            done_q     <= 1'b0;
            scan_idx_q <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            done_q     <= done_d;
            scan_idx_q <= scan_idx_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q   <= reload_d;
`endif
        end
    end

    assign w_sel_digit = count_q[{scan_idx_q, 2'b00} +: 4];

    assign busy      = (state_q != ST_IDLE);
    assign paused    = (state_q == ST_PAUSE);
    assign done      = done_q;
    assign count_bcd = count_q;
    assign an        = DIGITS'(1) << scan_idx_q;
    assign seg       = (w_sel_digit > 4'd9) ? 8'h00 : SEG_GLYPHS[w_sel_digit];

endmodule

`default_nettype wire

// File: tb/tb_multi_digit_countdown.sv
//----------------------------------------------------------------------------
// tb_multi_digit_countdown
// Directed stimulus with a decimal-arithmetic reference model checked every cycle.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_multi_digit_countdown;

    localparam int CLK_HZ  = 20;
    localparam int TICK_HZ = 1;
    localparam int SCAN_HZ = 10;
    localparam int DIGITS  = 2;
    localparam int TDIV    = CLK_HZ / TICK_HZ;
    localparam int SDIV    = CLK_HZ / SCAN_HZ;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                pause;
    logic                abort;
    logic [4*DIGITS-1:0] load_val;
    logic                busy;
    logic                paused;
    logic                done;
    logic [4*DIGITS-1:0] count_bcd;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   an;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    multi_digit_countdown #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .DIGITS  (DIGITS),
        .SCAN_HZ (SCAN_HZ)
    ) dut (
        .Clk100M   (clk),
        .Rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .load_val  (load_val),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .count_bcd (count_bcd),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    // Reference model: count held as a plain integer, phases as cycle counters.
    int m_st;      // 0 idle, 1 run, 2 pause
    int m_val;
    int m_rel;
    int m_pre;
    int m_scan;
    int m_idx;
    bit m_done;
    bit m_tick;
    bit m_acc;
    int m_lv;
    int m_d;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_st = 0; m_val = 0; m_rel = 0; m_pre = 0;
            m_scan = 0; m_idx = 0; m_done = 1'b0;
        end else begin
            m_tick = (m_st == 1) && (m_pre == TDIV - 1);
            m_acc  = start && !abort && (m_st == 0);
            m_done = 1'b0;
            if (m_acc) m_pre = 0;
            else if (m_st == 1) m_pre = (m_pre + 1) % TDIV;
            if (abort) begin
                m_st = 0;
            end else if (m_acc) begin
                m_lv = 0;
                for (int i = 0; i < DIGITS; i++) begin
                    m_d  = int'(load_val[4*i +: 4]);
                    m_lv = m_lv + ((m_d > 9) ? 9 : m_d) * pow10(i);
                end
                m_val = m_lv;
                m_rel = m_lv;
                if (m_lv == 0) m_done = 1'b1;
                else m_st = 1;
            end else if (pause && m_st != 0) begin
                m_st = (m_st == 1) ? 2 : 1;
            end else if (m_tick) begin
                m_val = m_val - 1;
                if (m_val == 0) begin
                    m_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    m_val = m_rel;
`else
                    m_st = 0;
`endif
                end
            end
            if (m_scan == SDIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % DIGITS;
            end else begin
                m_scan = m_scan + 1;
            end
        end
    end

    function automatic int model_bcd();
        int r = 0;
        for (int i = 0; i < DIGITS; i++)
            r = r | (((m_val / pow10(i)) % 10) << (4 * i));
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("model count_bcd", int'(count_bcd), model_bcd());
            check("model busy",      int'(busy),      int'(m_st != 0));
            check("model paused",    int'(paused),    int'(m_st == 2));
            check("model done",      int'(done),      int'(m_done));
            check("model an",        int'(an),        1 << m_idx);
            check("model seg",       int'(seg),       int'(glyph((m_val / pow10(m_idx)) % 10)));
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit s, input bit p, input bit a, input logic [7:0] v);
        start = s; pause = p; abort = a; load_val = v;
        wait_edges(1);
        start = 1'b0; pause = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_an(input logic [DIGITS-1:0] want, input string name);
        int k = 0;
        while (an !== want && k < 10) begin
            wait_edges(1);
            k++;
        end
        check(name, int'(an), int'(want));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; load_val = '0;
        wait_edges(3);
        check("reset count", int'(count_bcd), 0);
        check("reset busy",  int'(busy),      0);
        check("reset paused", int'(paused),   0);
        check("reset done",  int'(done),      0);
        check("reset an",    int'(an),        1);
        check("reset seg",   int'(seg),       8'h3F);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Pause in IDLE is ignored
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        check("idle pause paused", int'(paused), 0);
        check("idle pause busy",   int'(busy),   0);

        // 12 counts down once every 20 cycles
        pulse(1'b1, 1'b0, 1'b0, 8'h12);
        check("run12 +0 count", int'(count_bcd), 8'h12);
        wait_edges(19);
        check("run12 +19 count", int'(count_bcd), 8'h12);
        wait_edges(1);
        check("run12 +20 count", int'(count_bcd), 8'h11);
        wait_edges(20);
        check("run12 +40 count", int'(count_bcd), 8'h10);
        wait_edges(20);
        check("run12 +60 count", int'(count_bcd), 8'h09);
        check("run12 busy", int'(busy), 1);
        pulse(1'b1, 1'b0, 1'b0, 8'h55);
        check("start ignored in run", int'(count_bcd), 8'h09);
        pulse(1'b0, 1'b0, 1'b1, 8'h00);
        check("abort busy",  int'(busy),      0);
        check("abort count", int'(count_bcd), 8'h09);

        // Expiry from 02
        pulse(1'b1, 1'b0, 1'b0, 8'h02);
        wait_edges(39);
        check("exp +39 count", int'(count_bcd), 8'h01);
        check("exp +39 done",  int'(done),      0);
        wait_edges(1);
        check("exp +40 count", int'(count_bcd), 8'h00);
        check("exp +40 done",  int'(done),      1);
        check("exp +40 busy",  int'(busy),      0);
        wait_edges(1);
        check("exp +41 done",  int'(done),      0);

        // Zero start
        pulse(1'b1, 1'b0, 1'b0, 8'h00);
        check("zero start done", int'(done), 1);
        check("zero start busy", int'(busy), 0);
        wait_edges(1);
        check("zero start done off", int'(done), 0);

        // Clamp non-BCD digits to 9
        pulse(1'b1, 1'b0, 1'b0, 8'hAF);
        check("clamp count", int'(count_bcd), 8'h99);
        pulse(1'b0, 1'b0, 1'b1, 8'h00);

        // Pause for 30 cycles delays first decrement to +50
        pulse(1'b1, 1'b0, 1'b0, 8'h05);
        wait_edges(9);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        check("pause paused", int'(paused), 1);
        wait_edges(29);
        check("pause +39 paused", int'(paused), 1);
        pulse(1'b0, 1'b1, 1'b0, 8'h00);
        check("resume paused", int'(paused), 0);
        check("resume count",  int'(count_bcd), 8'h05);
        wait_edges(9);
        check("pause +49 count", int'(count_bcd), 8'h05);
        wait_edges(1);
        check("pause +50 count", int'(count_bcd), 8'h04);
        pulse(1'b0, 1'b0, 1'b1, 8'h00);

        // Abort beats start; count held; display shows held digits
        pulse(1'b1, 1'b0, 1'b0, 8'h30);
        wait_edges(25);
        check("pre-abort count", int'(count_bcd), 8'h29);
        pulse(1'b1, 1'b0, 1'b1, 8'h45);
        check("abort+start busy",  int'(busy),      0);
        check("abort+start count", int'(count_bcd), 8'h29);
        check("abort+start done",  int'(done),      0);
        wait_an(2'b10, "scan tens an");
        check("seg tens glyph", int'(seg), 8'h5B);
        wait_an(2'b01, "scan ones an");
        check("seg ones glyph", int'(seg), 8'h6F);
        pulse(1'b1, 1'b0, 1'b0, 8'h21);
        check("restart count", int'(count_bcd), 8'h21);
        check("restart busy",  int'(busy),      1);
        pulse(1'b0, 1'b0, 1'b1, 8'h00);

        // Reset mid-run
        pulse(1'b1, 1'b0, 1'b0, 8'h08);
        wait_edges(20);
        check("pre-reset count", int'(count_bcd), 8'h07);
        wait_edges(3);
        rst_n = 1'b0;
        wait_edges(1);
        check("rst count", int'(count_bcd), 0);
        check("rst busy",  int'(busy),      0);
        check("rst an",    int'(an),        1);
        check("rst done",  int'(done),      0);
        rst_n = 1'b1;
        wait_edges(1);
        check("post-rst +1 an", int'(an), 2'b01);
        wait_edges(1);
        check("post-rst +2 an", int'(an), 2'b10);
        wait_edges(4);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
